mdio_txn_arbiter: RTL and testbench

- Shares the single MDIO management frame engine among N_REQ requesters, e.g. link monitor, MAC config and debug port.
- Arbitrates round-robin and issues one frame at a time to the engine.
- Waits for engine completion or a timeout, then returns read data and status to the winning requester.
- Enforces a minimum idle gap between consecutive frames (preamble/turnaround recovery).

---
 rtl/mdio_txn_arbiter_if.sv | 42 ++++
 rtl/mdio_txn_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mdio_txn_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_txn_arbiter_if.sv
// mdio_txn_arbiter_if: bundles the requester-side and engine-side signals of the MDIO
// transaction arbiter.
//   slave  : arbiter view (consumes requests and engine status, drives grants,
//            responses and the engine command)
//   master : environment view (requesters plus frame engine)
// Requester payload buses are packed per requester: slice i of req_reg is [5i+4:5i],
// slice i of req_wdata is [16i+15:16i].
interface mdio_txn_arbiter_if #(
  parameter int unsigned N_REQ = 3
);
  // Requester side
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_op;
  logic [5*N_REQ-1:0]  req_reg;
  logic [16*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [15:0]         rsp_rdata;
  logic                rsp_err;
  // Frame engine side
  logic                eng_start;
  logic                eng_op;
  logic [4:0]          eng_reg;
  logic [15:0]         eng_wdata;
  logic                eng_busy;
  logic                eng_done;
  logic [15:0]         eng_rdata;
  // Status
  logic                busy;

  modport slave (
    input  req_valid, req_op, req_reg, req_wdata, eng_busy, eng_done, eng_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, eng_start, eng_op, eng_reg,
           eng_wdata, busy
  );

  modport master (
    output req_valid, req_op, req_reg, req_wdata, eng_busy, eng_done, eng_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, eng_start, eng_op, eng_reg,
           eng_wdata, busy
  );
endinterface

// File: rtl/mdio_txn_arbiter.sv
// mdio_txn_arbiter: shares one MDIO frame engine among N_REQ requesters.
// Round-robin grant, one frame in flight, completion or timeout, then a fixed idle gap.
// Ports:
//   clk_in : system clock, rising edge
//   reset  : asynchronous active-high reset; aborts any transaction silently
//   bus    : mdio_txn_arbiter_if.slave (requests, responses, engine command/status, busy)
// All outputs are registered and reset to zero.
module mdio_txn_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned GAP_CYC = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic                clk_in,
  input logic                reset,
  mdio_txn_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned GapW = $clog2(GAP_CYC + 2);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  // Wraps when GAP_CYC is 0; the gap state is never entered in that case.
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_REQ - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResp,
    StGap
  } state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]    win_q, win_d;
  logic               lat_op_q, lat_op_d;
  logic [4:0]         lat_reg_q, lat_reg_d;
  logic [15:0]        lat_wdata_q, lat_wdata_d;
  logic [TmoW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;

  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               eng_start_q, eng_start_d;
  logic               eng_op_q, eng_op_d;
  logic [4:0]         eng_reg_q, eng_reg_d;
  logic [15:0]        eng_wdata_q, eng_wdata_d;
  logic               busy_q, busy_d;

  // Round-robin scan: first set req_valid bit at or after rr_ptr, wrapping at N_REQ.
  logic               scan_found;
  logic [IdxW-1:0]    scan_win;
  logic [IdxW:0]      scan_pos;
  int unsigned        win_sel;
  logic [N_REQ-1:0]   win_onehot;

  always_comb begin
    scan_found = 1'b0;
    scan_win   = '0;
    scan_pos   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      scan_pos = {1'b0, rr_ptr_q} + (IdxW + 1)'(k);
      if (scan_pos >= (IdxW + 1)'(N_REQ)) begin
        scan_pos = scan_pos - (IdxW + 1)'(N_REQ);
      end
      if (!scan_found && bus.req_valid[scan_pos[IdxW-1:0]]) begin
        scan_found = 1'b1;
        scan_win   = scan_pos[IdxW-1:0];
      end
    end
  end

  assign win_sel    = 32'(scan_win);
  assign win_onehot = {{(N_REQ - 1){1'b0}}, 1'b1} << win_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    lat_op_d    = lat_op_q;
    lat_reg_d   = lat_reg_q;
    lat_wdata_d = lat_wdata_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    eng_start_d = 1'b0;
    eng_op_d    = eng_op_q;
    eng_reg_d   = eng_reg_q;
    eng_wdata_d = eng_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (scan_found) begin
          win_d       = scan_win;
          lat_op_d    = bus.req_op[scan_win];
          lat_reg_d   = bus.req_reg[5*win_sel +: 5];
          lat_wdata_d = bus.req_wdata[16*win_sel +: 16];
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // Hold off while the engine is still shifting a previous frame.
        if (!bus.eng_busy) begin
          eng_start_d = 1'b1;
          req_ready_d = win_onehot;
          eng_op_d    = lat_op_q;
          eng_reg_d   = lat_reg_q;
          eng_wdata_d = lat_wdata_q;
          rr_ptr_d    = (win_q == IdxLast) ? '0 : win_q + 1'b1;
          tmo_cnt_d   = '0;
          state_d     = StWait;
        end
      end
      StWait: begin
        // Completion takes priority over a timeout expiring in the same cycle.
        if (bus.eng_done) begin
          rsp_rdata_d = lat_op_q ? bus.eng_rdata : 16'h0000;
          rsp_err_d   = 1'b0;
          rsp_valid_d = win_onehot;
          state_d     = StResp;
        end else if (tmo_cnt_q == TmoLast) begin
          rsp_rdata_d = 16'hFFFF;
          rsp_err_d   = 1'b1;
          rsp_valid_d = win_onehot;
          state_d     = StResp;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StResp: begin
        gap_cnt_d = '0;
        state_d   = (GAP_CYC == 0) ? StIdle : StGap;
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      lat_op_q    <= 1'b0;
      lat_reg_q   <= '0;
      lat_wdata_q <= '0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      eng_start_q <= 1'b0;
      eng_op_q    <= 1'b0;
      eng_reg_q   <= '0;
      eng_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      lat_op_q    <= lat_op_d;
      lat_reg_q   <= lat_reg_d;
      lat_wdata_q <= lat_wdata_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      eng_start_q <= eng_start_d;
      eng_op_q    <= eng_op_d;
      eng_reg_q   <= eng_reg_d;
      eng_wdata_q <= eng_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_op    = eng_op_q;
  assign bus.eng_reg   = eng_reg_q;
  assign bus.eng_wdata = eng_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mdio_txn_arbiter.sv
// tb_mdio_txn_arbiter: scoreboard bench for mdio_txn_arbiter.
// Stimulus computes the expected grant order (round-robin after the last winner), the engine
// plan and the expected response per transaction and queues them; a monitor and a behavioural
// engine pop and compare whenever the DUT presents a grant, a frame start or a response.
module tb_mdio_txn_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned GAP  = 4;
  localparam int unsigned TMO  = 64;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  mdio_txn_arbiter_if #(.N_REQ(NREQ)) bus ();

  mdio_txn_arbiter #(
    .N_REQ  (NREQ),
    .GAP_CYC(GAP),
    .TIMEOUT(TMO)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        err;
    int          lat;
  } rsp_t;

  typedef struct {
    logic        op;
    logic [4:0]  rg;
    logic [15:0] wd;
    int          dly;
    logic [15:0] rd;
  } plan_t;

  rsp_t  exp_q[$];
  int    grant_q[$];
  plan_t plan_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rr_model    = 0;

  logic        cur_op[NREQ];
  logic [4:0]  cur_reg[NREQ];
  logic [15:0] cur_wd[NREQ];
  int          dly_a[NREQ];
  logic [15:0] rd_a[NREQ];

  always @(posedge clk_in) cyc <= cyc + 1;

  always_comb begin
    bus.req_op    = '0;
    bus.req_reg   = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_op[i]          = cur_op[i];
      bus.req_reg[5*i +: 5]  = cur_reg[i];
      bus.req_wdata[16*i +: 16] = cur_wd[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic randomize_all();
    int r;
    for (int i = 0; i < int'(NREQ); i++) begin
      cur_op[i]  = 1'($urandom_range(0, 1));
      cur_reg[i] = 5'($urandom);
      cur_wd[i]  = 16'($urandom);
      rd_a[i]    = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       dly_a[i] = $urandom_range(1, 20);
      else if (r == 7) dly_a[i] = TMO - 1;
      else if (r == 8) dly_a[i] = TMO;
      else             dly_a[i] = $urandom_range(21, TMO - 2);
    end
  endtask

  task automatic push_txn(input int i);
    plan_t p;
    rsp_t  e;
    p.op = cur_op[i]; p.rg = cur_reg[i]; p.wd = cur_wd[i]; p.dly = dly_a[i]; p.rd = rd_a[i];
    plan_q.push_back(p);
    grant_q.push_back(i);
    e.idx = i;
    if (dly_a[i] >= int'(TMO)) begin
      e.data = 16'hFFFF; e.err = 1'b1; e.lat = TMO;
    end else begin
      e.data = cur_op[i] ? rd_a[i] : 16'h0000; e.err = 1'b0; e.lat = dly_a[i] + 1;
    end
    exp_q.push_back(e);
  endtask

  // Drive a request mask. hold=0: each set bit is served once and dropped on its ready.
  // hold=1: the mask stays asserted for n_hold grants.
  task automatic run_reqs(input logic [NREQ-1:0] mask, input bit hold, input int n_hold,
                          input bit chk_lat, input int busy_hold);
    int n, p, grants, cnt, starts_seen;
    bit used[NREQ];
    p = rr_model;
    n = hold ? n_hold : $countones(mask);
    for (int i = 0; i < int'(NREQ); i++) used[i] = 1'b0;
    for (int g = 0; g < n; g++) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        int i;
        i = (p + k) % NREQ;
        if (mask[i] && (hold || !used[i])) begin
          push_txn(i);
          used[i] = 1'b1;
          p = (i + 1) % NREQ;
          break;
        end
      end
    end
    rr_model = p;
    if (busy_hold > 0) bus.eng_busy = 1'b1;
    bus.req_valid = mask;
    grants = 0; cnt = 0; starts_seen = 0;
    while (grants < n && cnt < 20000) begin
      @(negedge clk_in);
      if (chk_lat && cnt == 0) check("latency_no_start_cyc1", bus.eng_start, 0);
      if (chk_lat && cnt == 1) check("latency_start_cyc2", bus.eng_start, 1);
      if (busy_hold > 0) begin
        if (cnt < busy_hold) begin
          if (bus.eng_start) starts_seen++;
        end else if (cnt == busy_hold) begin
          check("busy_hold_no_start", starts_seen, 0);
          check("busy_in_issue", bus.busy, 1);
          bus.eng_busy = 1'b0;
        end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.req_ready[i]) begin
          grants++;
          if (!hold) begin
            bus.req_valid[i] = 1'b0;
            cur_op[i]  = 1'($urandom_range(0, 1));
            cur_reg[i] = 5'($urandom);
            cur_wd[i]  = 16'($urandom);
          end
        end
      end
      if (hold && grants >= n) bus.req_valid = '0;
      cnt++;
    end
    if (grants < n) check("grant_timeout", grants, n);
    bus.req_valid = '0;
    bus.eng_busy  = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || bus.busy) && cnt < 5000) begin
      @(negedge clk_in);
      cnt++;
    end
    check("return_to_idle", (exp_q.size() == 0 && !bus.busy), 1);
  endtask

  // Monitor: grants, start spacing, responses.
  initial begin
    int  outstanding;
    int  last_start;
    bit  have_start;
    outstanding = 0; last_start = 0; have_start = 1'b0;
    forever begin
      @(negedge clk_in);
      if (reset) begin
        outstanding = 0;
        have_start  = 1'b0;
      end else begin
        if (bus.eng_start || bus.req_ready != '0) begin
          if (grant_q.size() == 0) begin
            check("unexpected_grant", bus.req_ready, 0);
          end else begin
            int g;
            g = grant_q.pop_front();
            check("grant", bus.req_ready, 64'(1) << g);
          end
          check("start_with_ready", bus.eng_start, 1);
          if (have_start) check("start_spacing", (cyc - last_start) >= int'(GAP + 3), 1);
          have_start  = 1'b1;
          last_start  = cyc;
          outstanding++;
        end
        if (bus.rsp_valid != '0) begin
          check("rsp_after_ready", outstanding > 0, 1);
          if (outstanding > 0) outstanding--;
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", bus.rsp_valid, 0);
          end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp_valid", bus.rsp_valid, 64'(1) << e.idx);
            check("rsp_rdata", bus.rsp_rdata, e.data);
            check("rsp_err", bus.rsp_err, e.err);
            check("rsp_latency", cyc - last_start, e.lat);
          end
        end
      end
    end
  end

  // Behavioural frame engine.
  initial begin
    bus.eng_done  = 1'b0;
    bus.eng_rdata = 16'h5A5A;
    forever begin
      @(negedge clk_in);
      if (bus.eng_start && !reset) begin
        if (plan_q.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          plan_t p;
          p = plan_q.pop_front();
          check("eng_op", bus.eng_op, p.op);
          check("eng_reg", bus.eng_reg, p.rg);
          check("eng_wdata", bus.eng_wdata, p.wd);
          // A timed-out frame still completes, but only once the arbiter is in RESP.
          repeat ((p.dly >= int'(TMO)) ? TMO : p.dly) @(posedge clk_in);
          #1 bus.eng_done = 1'b1; bus.eng_rdata = p.rd;
          @(posedge clk_in);
          #1 bus.eng_done = 1'b0; bus.eng_rdata = 16'($urandom);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] mask;
    bus.req_valid = '0;
    bus.eng_busy  = 1'b0;
    randomize_all();
    repeat (3) @(negedge clk_in);
    check("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                            bus.eng_start, bus.eng_op, bus.eng_reg, bus.eng_wdata}, 0);
    check("reset_busy", bus.busy, 0);
    reset = 1'b0;
    @(negedge clk_in);

    // Single read with 2-cycle start latency.
    cur_op[0] = 1'b1; cur_reg[0] = 5'h01; dly_a[0] = 40; rd_a[0] = 16'h782D;
    run_reqs(3'b001, 1'b0, 0, 1'b1, 0);
    wait_idle();

    // Write from requester 2; engine data must be masked to zero.
    randomize_all();
    cur_op[2] = 1'b0; cur_reg[2] = 5'h00; cur_wd[2] = 16'h3100; dly_a[2] = 12;
    rd_a[2] = 16'hBEEF;
    run_reqs(3'b100, 1'b0, 0, 1'b0, 0);
    wait_idle();

    // Fairness with all requesters held: 0,1,2,0.
    randomize_all();
    run_reqs(3'b111, 1'b1, 4, 1'b0, 0);
    wait_idle();

    // Single requester held continuously: back-to-back with gap.
    randomize_all();
    run_reqs(3'b010, 1'b1, 3, 1'b0, 0);
    wait_idle();

    // Timeout.
    randomize_all();
    cur_op[1] = 1'b1; dly_a[1] = TMO;
    run_reqs(3'b010, 1'b0, 0, 1'b0, 0);
    wait_idle();

    // Engine busy holds the issue for 10 cycles.
    randomize_all();
    dly_a[0] = 5;
    run_reqs(3'b001, 1'b0, 0, 1'b0, 10);
    wait_idle();

    // eng_done coincident with timeout expiry.
    randomize_all();
    cur_op[2] = 1'b1; dly_a[2] = TMO - 1; rd_a[2] = 16'h1234;
    run_reqs(3'b100, 1'b0, 0, 1'b0, 0);
    wait_idle();

    // Randomized rounds, sometimes overlapping the previous transaction.
    repeat (25) begin
      randomize_all();
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_reqs(mask, 1'b0, 0, 1'b0, 0);
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();

    // Reset during WAIT: silent abort, pointer back to requester 0.
    randomize_all();
    dly_a[1] = TMO;
    run_reqs(3'b010, 1'b0, 0, 1'b0, 0);
    repeat (5) @(negedge clk_in);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                                  bus.eng_start, bus.eng_op, bus.eng_reg, bus.eng_wdata}, 0);
    check("async_reset_busy", bus.busy, 0);
    exp_q.delete();
    grant_q.delete();
    rr_model = 0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    repeat (TMO + 10) @(negedge clk_in);
    randomize_all();
    run_reqs(3'b111, 1'b0, 0, 1'b0, 0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
